// File: rtl/axum_xbar.sv
// axum_xbar: round-robin N-host to M-device shared bus with base/mask decode and unmapped-address error response
module axum_xbar #(
   parameter int NrHosts      = 2,
   parameter int NrDevices    = 4,
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    host_req_i     [NrHosts],
   output logic                    host_gnt_o     [NrHosts],
   input  logic [AddressWidth-1:0] host_addr_i    [NrHosts],
   input  logic                    host_we_i      [NrHosts],
   input  logic [DataWidth/8-1:0]  host_be_i      [NrHosts],
   input  logic [DataWidth-1:0]    host_wdata_i   [NrHosts],
   output logic                    host_rvalid_o  [NrHosts],
   output logic [DataWidth-1:0]    host_rdata_o   [NrHosts],
   output logic                    host_err_o     [NrHosts],
   output logic                    device_req_o   [NrDevices],
   output logic [AddressWidth-1:0] device_addr_o  [NrDevices],
   output logic                    device_we_o    [NrDevices],
   output logic [DataWidth/8-1:0]  device_be_o    [NrDevices],
   output logic [DataWidth-1:0]    device_wdata_o [NrDevices],
   input  logic                    device_rvalid_i[NrDevices],
   input  logic [DataWidth-1:0]    device_rdata_i [NrDevices],
   input  logic                    device_err_i   [NrDevices],
   input  logic [AddressWidth-1:0] cfg_device_addr_base[NrDevices],
   input  logic [AddressWidth-1:0] cfg_device_addr_mask[NrDevices]
);
   localparam int HW = NrHosts > 1 ? $clog2(NrHosts) : 1;
   localparam int DW = NrDevices > 1 ? $clog2(NrDevices) : 1;
   logic [HW-1:0] rr_q, gnt_idx, pend_host_q;
   logic [DW-1:0] dev_idx, pend_dev_q;
   logic gnt_any, dev_hit, pend_valid_q, pend_unmapped_q;
   logic rsp_valid, rsp_err;
   logic [DataWidth-1:0] rsp_data;
   logic [AddressWidth-1:0] sel_addr;
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int i = NrHosts - 1; i >= 0; i--) begin
         if (host_req_i[(int'(rr_q) + i) % NrHosts]) begin
            gnt_any = 1'b1;
            gnt_idx = HW'((int'(rr_q) + i) % NrHosts);
         end
      end
      gnt_any = gnt_any & rst_ni;
   end
   assign sel_addr = host_addr_i[gnt_idx];
   always_comb begin
      dev_hit = 1'b0;
      dev_idx = '0;
      for (int d = NrDevices - 1; d >= 0; d--) begin
         if ((sel_addr & cfg_device_addr_mask[d]) == (cfg_device_addr_base[d] & cfg_device_addr_mask[d])) begin
            dev_hit = 1'b1;
            dev_idx = DW'(d);
         end
      end
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr_q            <= '0;
         pend_valid_q    <= 1'b0;
         pend_host_q     <= '0;
         pend_dev_q      <= '0;
         pend_unmapped_q <= 1'b0;
      end else begin
         pend_valid_q <= gnt_any;
         if (gnt_any) begin
            rr_q            <= gnt_idx == HW'(NrHosts - 1) ? '0 : gnt_idx + 1'b1;
            pend_host_q     <= gnt_idx;
            pend_dev_q      <= dev_idx;
            pend_unmapped_q <= !dev_hit;
         end
      end
   end
   assign rsp_valid = rst_ni && pend_valid_q && (pend_unmapped_q || device_rvalid_i[pend_dev_q]);
   assign rsp_err   = pend_unmapped_q || device_err_i[pend_dev_q];
   assign rsp_data  = pend_unmapped_q ? '0 : device_rdata_i[pend_dev_q];
   for (genvar h = 0; h < NrHosts; h++) begin : g_host
      assign host_gnt_o[h]    = gnt_any && gnt_idx == HW'(h);
      assign host_rvalid_o[h] = rsp_valid && pend_host_q == HW'(h);
      assign host_err_o[h]    = host_rvalid_o[h] && rsp_err;
      assign host_rdata_o[h]  = host_rvalid_o[h] ? rsp_data : '0;
   end
   for (genvar d = 0; d < NrDevices; d++) begin : g_dev
      assign device_req_o[d]   = gnt_any && dev_hit && dev_idx == DW'(d);
      assign device_addr_o[d]  = gnt_any ? sel_addr : '0;
      assign device_we_o[d]    = gnt_any && host_we_i[gnt_idx];
      assign device_be_o[d]    = gnt_any ? host_be_i[gnt_idx] : '0;
      assign device_wdata_o[d] = gnt_any ? host_wdata_i[gnt_idx] : '0;
   end
endmodule

// File: tb/tb_axum_xbar.sv
// tb_axum_xbar: directed checks of arbitration, decode, error response and reset behaviour of axum_xbar
module tb_axum_xbar;
   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        host_req_i[2], host_gnt_o[2], host_we_i[2], host_rvalid_o[2], host_err_o[2];
   logic [31:0] host_addr_i[2], host_wdata_i[2], host_rdata_o[2];
   logic [3:0]  host_be_i[2];
   logic        device_req_o[4], device_we_o[4], device_rvalid_i[4], device_err_i[4];
   logic [31:0] device_addr_o[4], device_wdata_o[4], device_rdata_i[4];
   logic [3:0]  device_be_o[4];
   logic [31:0] cfg_device_addr_base[4], cfg_device_addr_mask[4];
   logic        dev_err_flag[4];
   logic [1:0]  gnt_v, rv_v, err_v;
   logic [3:0]  dreq_v;
   int          total = 0, passed = 0, fails = 0;
   always #5 clk_i = ~clk_i;
   axum_xbar dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
      .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
      .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
      .device_req_o(device_req_o), .device_addr_o(device_addr_o), .device_we_o(device_we_o),
      .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
      .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i), .device_err_i(device_err_i),
      .cfg_device_addr_base(cfg_device_addr_base), .cfg_device_addr_mask(cfg_device_addr_mask)
   );
   assign gnt_v  = {host_gnt_o[1], host_gnt_o[0]};
   assign rv_v   = {host_rvalid_o[1], host_rvalid_o[0]};
   assign err_v  = {host_err_o[1], host_err_o[0]};
   assign dreq_v = {device_req_o[3], device_req_o[2], device_req_o[1], device_req_o[0]};
   always @(posedge clk_i) begin
      for (int d = 0; d < 4; d++) begin
         device_rvalid_i[d] <= device_req_o[d];
         device_err_i[d]    <= device_req_o[d] && dev_err_flag[d];
         device_rdata_i[d]  <= dev_err_flag[d] ? 32'hDEADBEEF : {8'hA0, 8'(d), device_addr_o[d][15:0]};
      end
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic rst, input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1);
      @(negedge clk_i);
      rst_ni = rst;
      host_req_i[0] = req[0];
      host_req_i[1] = req[1];
      host_addr_i[0] = a0;
      host_addr_i[1] = a1;
      #1;
   endtask
   initial begin
      for (int h = 0; h < 2; h++) begin
         host_req_i[h] = 1'b0; host_we_i[h] = 1'b0; host_be_i[h] = 4'hF;
         host_wdata_i[h] = 32'h0; host_addr_i[h] = 32'h0;
      end
      for (int d = 0; d < 4; d++) dev_err_flag[d] = 1'b0;
      cfg_device_addr_base = '{32'h0010_0000, 32'h0002_0000, 32'h0003_0000, 32'h0005_0000};
      cfg_device_addr_mask = '{32'hFFFF_C000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};
      rst_ni = 1'b0;
      drive(1'b0, 2'b11, 32'h0010_0000, 32'h0010_0000);
      chk("rst_gnt", 32'(gnt_v), 32'h0);
      chk("rst_dreq", 32'(dreq_v), 32'h0);
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      drive(1'b1, 2'b00, 32'h0, 32'h0);
      chk("post_rst_rv", 32'(rv_v), 32'h0);
      chk("post_rst_rdata0", host_rdata_o[0], 32'h0);
      chk("post_rst_err", 32'(err_v), 32'h0);
      drive(1'b1, 2'b11, 32'h0010_0010, 32'h0010_0020);
      chk("rr1_gnt", 32'(gnt_v), 32'h1);
      chk("rr1_dreq", 32'(dreq_v), 32'h1);
      chk("rr1_addr_fwd", device_addr_o[3], 32'h0010_0010);
      drive(1'b1, 2'b11, 32'h0010_0010, 32'h0010_0020);
      chk("rr2_gnt", 32'(gnt_v), 32'h2);
      chk("rr2_rv", 32'(rv_v), 32'h1);
      chk("rr2_rdata0", host_rdata_o[0], 32'hA000_0010);
      chk("rr2_rdata1_idle", host_rdata_o[1], 32'h0);
      drive(1'b1, 2'b11, 32'h0010_0030, 32'h0010_0020);
      chk("rr3_gnt", 32'(gnt_v), 32'h1);
      chk("rr3_rv", 32'(rv_v), 32'h2);
      chk("rr3_rdata1", host_rdata_o[1], 32'hA000_0020);
      drive(1'b1, 2'b11, 32'h0010_0030, 32'h0010_0040);
      chk("rr4_gnt", 32'(gnt_v), 32'h2);
      chk("rr4_rdata0", host_rdata_o[0], 32'hA000_0030);
      drive(1'b1, 2'b00, 32'h0, 32'h0);
      chk("rr5_gnt", 32'(gnt_v), 32'h0);
      chk("rr5_dreq", 32'(dreq_v), 32'h0);
      chk("rr5_rdata1", host_rdata_o[1], 32'hA000_0040);
      drive(1'b1, 2'b10, 32'h0, 32'h0002_0004);
      chk("gpio_gnt", 32'(gnt_v), 32'h2);
      chk("gpio_dreq", 32'(dreq_v), 32'h2);
      drive(1'b1, 2'b11, 32'h0010_0040, 32'h0002_0008);
      chk("both_gnt_h0", 32'(gnt_v), 32'h1);
      chk("both_dreq", 32'(dreq_v), 32'h1);
      chk("gpio_rdata1", host_rdata_o[1], 32'hA001_0004);
      drive(1'b1, 2'b10, 32'h0, 32'h0002_0008);
      chk("both_gnt_h1", 32'(gnt_v), 32'h2);
      chk("both_dreq_gpio", 32'(dreq_v), 32'h2);
      chk("both_rdata0", host_rdata_o[0], 32'hA000_0040);
      drive(1'b1, 2'b01, 32'h9000_0000, 32'h0);
      chk("unm_gnt", 32'(gnt_v), 32'h1);
      chk("unm_dreq", 32'(dreq_v), 32'h0);
      chk("gpio2_rdata1", host_rdata_o[1], 32'hA001_0008);
      drive(1'b1, 2'b00, 32'h0, 32'h0);
      chk("unm_rv", 32'(rv_v), 32'h1);
      chk("unm_err", 32'(err_v), 32'h1);
      chk("unm_rdata", host_rdata_o[0], 32'h0);
      @(negedge clk_i);
      cfg_device_addr_base[0] = 32'h0004_0000;
      cfg_device_addr_mask[0] = 32'hFFFF_0000;
      cfg_device_addr_base[2] = 32'h0004_0000;
      drive(1'b1, 2'b01, 32'h0004_0000, 32'h0);
      chk("ovl_gnt", 32'(gnt_v), 32'h1);
      chk("ovl_dreq", 32'(dreq_v), 32'h1);
      chk("ovl_addr_dev2", device_addr_o[2], 32'h0004_0000);
      drive(1'b1, 2'b00, 32'h0, 32'h0);
      cfg_device_addr_base[0] = 32'h0010_0000;
      cfg_device_addr_mask[0] = 32'hFFFF_C000;
      cfg_device_addr_base[2] = 32'h0003_0000;
      chk("ovl_rdata0", host_rdata_o[0], 32'hA000_0000);
      chk("ovl_err", 32'(err_v), 32'h0);
      dev_err_flag[2] = 1'b1;
      drive(1'b1, 2'b10, 32'h0, 32'h0003_0010);
      chk("tmr_gnt", 32'(gnt_v), 32'h2);
      chk("tmr_dreq", 32'(dreq_v), 32'h4);
      drive(1'b1, 2'b00, 32'h0, 32'h0);
      dev_err_flag[2] = 1'b0;
      chk("tmr_rv", 32'(rv_v), 32'h2);
      chk("tmr_err", 32'(err_v), 32'h2);
      chk("tmr_rdata1", host_rdata_o[1], 32'hDEAD_BEEF);
      drive(1'b1, 2'b01, 32'h0010_0000, 32'h0);
      chk("pre_rst_gnt", 32'(gnt_v), 32'h1);
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      chk("midrst_rv", 32'(rv_v), 32'h0);
      drive(1'b1, 2'b11, 32'h0010_0100, 32'h0010_0200);
      chk("after_rst_rv", 32'(rv_v), 32'h0);
      chk("after_rst_gnt", 32'(gnt_v), 32'h1);
      drive(1'b1, 2'b10, 32'h0, 32'h0010_0200);
      chk("after_rst_gnt2", 32'(gnt_v), 32'h2);
      chk("after_rst_rdata0", host_rdata_o[0], 32'hA000_0100);
      drive(1'b1, 2'b00, 32'h0, 32'h0);
      chk("after_rst_rdata1", host_rdata_o[1], 32'hA000_0200);
      chk("after_rst_err", 32'(err_v), 32'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
